// File: rtl/dcache_wb_buffer_pkg.sv
// Shared data-cache definitions used by the write-back buffer.
package dcache_wb_buffer_pkg;

    localparam int unsigned DCACHE_ADDR_WIDTH  = 32;
    localparam int unsigned DCACHE_LINE_WIDTH  = 128;
    localparam int unsigned DCACHE_OFFSET_BITS = $clog2(DCACHE_LINE_WIDTH / 8);
    localparam int unsigned DCACHE_WB_DEPTH    = 4;

    typedef struct packed {
        logic                         valid;
        logic [DCACHE_ADDR_WIDTH-1:0] addr;
        logic [DCACHE_LINE_WIDTH-1:0] data;
    } type_wb_entry_s;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_FILL,
        WB_DRAIN
    } type_wb_state_e;

endpackage

// File: rtl/dcache_wb_buffer_if.sv
// Cache-side and memory-side signals of the write-back buffer; slave = buffer, master = environment.
interface dcache_wb_buffer_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128
);
    logic              wb_push_i;
    logic [ADDR_W-1:0] dcache2mem_addr_i;
    logic [LINE_W-1:0] dcache2mem_data_i;
    logic              wb_full_o;
    logic              wb_empty_o;
    logic              fill_req_i;
    logic [ADDR_W-1:0] fill_addr_i;
    logic              fill_ack_o;
    logic [LINE_W-1:0] fill_data_o;
    logic              mem_req_o;
    logic              mem_wr_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  wb_push_i, dcache2mem_addr_i, dcache2mem_data_i, fill_req_i, fill_addr_i,
               mem_rdata_i, mem_ack_i,
        output wb_full_o, wb_empty_o, fill_ack_o, fill_data_o, mem_req_o, mem_wr_o,
               mem_addr_o, mem_wdata_o
    );

    modport master (
        output wb_push_i, dcache2mem_addr_i, dcache2mem_data_i, fill_req_i, fill_addr_i,
               mem_rdata_i, mem_ack_i,
        input  wb_full_o, wb_empty_o, fill_ack_o, fill_data_o, mem_req_o, mem_wr_o,
               mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_wb_buffer_wb_addr_match.sv
// DEPTH-wide line-tag compare; on several hits the entry closest to newest_i wins.
module dcache_wb_buffer_wb_addr_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 28,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [DEPTH-1:0][TAG_W-1:0] tag_i,
    input  logic [TAG_W-1:0]            query_i,
    input  logic [PTR_W-1:0]            newest_i,
    output logic                        hit_o,
    output logic [PTR_W-1:0]            idx_o
);
    logic [PTR_W-1:0] pos;

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pos = newest_i - PTR_W'(i);
            if (!hit_o && valid_i[pos] && (tag_i[pos] == query_i)) begin
                hit_o = 1'b1;
                idx_o = pos;
            end
        end
    end
endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer: queues evicted lines, arbitrates the memory port between fills and drains.
// Define DCACHE_WB_FWD_EN to serve fills that hit a queued line directly from the buffer.
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = DCACHE_WB_DEPTH,
    parameter int unsigned ADDR_W = DCACHE_ADDR_WIDTH,
    parameter int unsigned LINE_W = DCACHE_LINE_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    dcache_wb_buffer_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OFF   = DCACHE_OFFSET_BITS;
    localparam int unsigned TAG_W = ADDR_W - OFF;

    logic [DEPTH-1:0]              valid_q;
    logic [DEPTH-1:0][TAG_W-1:0]   tag_q;
    logic [DEPTH-1:0][LINE_W-1:0]  data_q;
    logic [PTR_W-1:0]              head_q, tail_q;
    logic [CNT_W-1:0]              count_q, count_d;
    type_wb_state_e                state_q;

    logic              wb_full_q, wb_empty_q, fill_ack_q, mem_req_q, mem_wr_q;
    logic [LINE_W-1:0] fill_data_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic [DEPTH-1:0]  head_mask;
    logic              push_hit, fill_hit;
    logic [PTR_W-1:0]  push_idx, fill_idx;
    logic              full, push_coal, push_alloc, drain_done;
    logic              fill_new, fill_fwd, fill_start, drain_start;
    logic [LINE_W-1:0] drain_data, fill_fwd_data;

    // The line being written to memory must not absorb new data; a push to it allocates afresh.
    always_comb begin
        head_mask = '0;
        if (state_q == WB_DRAIN) head_mask[head_q] = 1'b1;
    end

    dcache_wb_buffer_wb_addr_match #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .PTR_W (PTR_W)
    ) u_push_match (
        .valid_i  (valid_q & ~head_mask),
        .tag_i    (tag_q),
        .query_i  (bus.dcache2mem_addr_i[ADDR_W-1:OFF]),
        .newest_i (tail_q - PTR_W'(1)),
        .hit_o    (push_hit),
        .idx_o    (push_idx)
    );

    dcache_wb_buffer_wb_addr_match #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .PTR_W (PTR_W)
    ) u_fill_match (
        .valid_i  (valid_q),
        .tag_i    (tag_q),
        .query_i  (bus.fill_addr_i[ADDR_W-1:OFF]),
        .newest_i (tail_q - PTR_W'(1)),
        .hit_o    (fill_hit),
        .idx_o    (fill_idx)
    );

    always_comb begin
        full       = (count_q == CNT_W'(DEPTH));
        push_coal  = bus.wb_push_i && push_hit;
        push_alloc = bus.wb_push_i && !push_hit && !full;
        drain_done = (state_q == WB_DRAIN) && bus.mem_ack_i;
        count_d    = count_q + CNT_W'(push_alloc) - CNT_W'(drain_done);
        // fill_req_i is still high in the cycle fill_ack_o is shown; do not restart it.
        fill_new   = bus.fill_req_i && !fill_ack_q && (state_q != WB_FILL);
`ifdef DCACHE_WB_FWD_EN
        fill_fwd   = fill_new && fill_hit;
`else
        fill_fwd   = 1'b0;
`endif
        fill_start  = (state_q == WB_IDLE) && fill_new && !fill_hit && !full;
        drain_start = (state_q == WB_IDLE) && !fill_start && (count_q != '0);
        drain_data  = (push_coal && (push_idx == head_q)) ? bus.dcache2mem_data_i
                                                          : data_q[head_q];
        fill_fwd_data = data_q[fill_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= WB_IDLE;
            wb_full_q   <= 1'b0;
            wb_empty_q  <= 1'b1;
            fill_ack_q  <= 1'b0;
            fill_data_q <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            fill_ack_q <= 1'b0;
            if (push_alloc) begin
                valid_q[tail_q] <= 1'b1;
                tag_q[tail_q]   <= bus.dcache2mem_addr_i[ADDR_W-1:OFF];
                data_q[tail_q]  <= bus.dcache2mem_data_i;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (push_coal) data_q[push_idx] <= bus.dcache2mem_data_i;
            if (drain_done) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            count_q    <= count_d;
            wb_full_q  <= (count_d == CNT_W'(DEPTH));
            wb_empty_q <= (count_d == '0);
            if (fill_fwd) begin
                fill_ack_q  <= 1'b1;
                fill_data_q <= fill_fwd_data;
            end

            unique case (state_q)
                WB_IDLE: begin
                    if (fill_start) begin
                        state_q    <= WB_FILL;
                        mem_req_q  <= 1'b1;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= {bus.fill_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
                    end else if (drain_start) begin
                        state_q     <= WB_DRAIN;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= {tag_q[head_q], {OFF{1'b0}}};
                        mem_wdata_q <= drain_data;
                    end
                end
                WB_FILL: begin
                    if (bus.mem_ack_i) begin
                        state_q     <= WB_IDLE;
                        mem_req_q   <= 1'b0;
                        fill_ack_q  <= 1'b1;
                        fill_data_q <= bus.mem_rdata_i;
                    end
                end
                WB_DRAIN: begin
                    if (bus.mem_ack_i) begin
                        state_q   <= WB_IDLE;
                        mem_req_q <= 1'b0;
                        mem_wr_q  <= 1'b0;
                    end
                end
                default: state_q <= WB_IDLE;
            endcase
        end
    end

    assign bus.wb_full_o   = wb_full_q;
    assign bus.wb_empty_o  = wb_empty_q;
    assign bus.fill_ack_o  = fill_ack_q;
    assign bus.fill_data_o = fill_data_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_wr_o    = mem_wr_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer with a logging memory responder.
module tb_dcache_wb_buffer;
    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_bad = 0;
    logic ack_en;
    logic inject_ack;

    logic         log_wr[$];
    logic [31:0]  log_addr[$];
    logic [127:0] log_data[$];

    localparam logic [127:0] D1  = 128'h1111_0001_2222_0002_3333_0003_4444_0004;
    localparam logic [127:0] DA  = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DB  = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [127:0] DX  = 128'h5555_6666_7777_8888_9999_0000_1212_3434;

    dcache_wb_buffer_if #(.ADDR_W(32), .LINE_W(128)) bus ();

    dcache_wb_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    // Memory responder: acks a pending request one cycle after it appears and logs it.
    initial begin
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_ack_i) begin
                bus.mem_ack_i = 1'b0;
            end else if (inject_ack) begin
                bus.mem_ack_i = 1'b1;
            end else if (ack_en && bus.mem_req_o) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = {32'hDEAD_BEEF, 64'h0, bus.mem_addr_o};
                log_wr.push_back(bus.mem_wr_o);
                log_addr.push_back(bus.mem_addr_o);
                log_data.push_back(bus.mem_wdata_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic wr,
                             input logic [31:0] addr, input logic [127:0] data);
        check_eq({tag, "_seen"}, log_addr.size() > idx, 1'b1);
        if (log_addr.size() > idx) begin
            check_eq({tag, "_wr"}, log_wr[idx], wr);
            check_eq({tag, "_addr"}, log_addr[idx], addr);
            if (wr) check_eq({tag, "_data"}, log_data[idx], data);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [127:0] d);
        bus.wb_push_i         = 1'b1;
        bus.dcache2mem_addr_i = a;
        bus.dcache2mem_data_i = d;
        step();
        bus.wb_push_i = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!(bus.wb_empty_o && !bus.mem_req_o) && n < 100) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, n < 100, 1'b1);
    endtask

    task automatic wait_fill(input string tag, output logic [127:0] data, output int cycles);
        int n = 0;
        do begin
            step();
            n++;
        end while (!bus.fill_ack_o && n < 100);
        cycles = n;
        data   = bus.fill_data_o;
        check_eq({tag, "_ack"}, bus.fill_ack_o, 1'b1);
        bus.fill_req_i = 1'b0;
    endtask

    initial begin
        int           base;
        int           cyc;
        logic [127:0] fdata;
        logic [31:0]  full_addr[4];

        full_addr[0] = 32'h0000_0100;
        full_addr[1] = 32'h0000_0200;
        full_addr[2] = 32'h0000_0300;
        full_addr[3] = 32'h0000_0400;

        rst_n                 = 1'b0;
        ack_en                = 1'b1;
        inject_ack            = 1'b0;
        bus.wb_push_i         = 1'b0;
        bus.dcache2mem_addr_i = '0;
        bus.dcache2mem_data_i = '0;
        bus.fill_req_i        = 1'b0;
        bus.fill_addr_i       = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        check_eq("rst_empty", bus.wb_empty_o, 1'b1);
        check_eq("rst_full", bus.wb_full_o, 1'b0);
        check_eq("rst_req", bus.mem_req_o, 1'b0);
        check_eq("rst_fill_ack", bus.fill_ack_o, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr_o, 32'h0);

        // Single push drains to memory
        base = log_addr.size();
        push(32'h0000_1000, D1);
        check_eq("push_not_empty", bus.wb_empty_o, 1'b0);
        wait_empty("single");
        check_log("single_drain", base, 1'b1, 32'h0000_1000, D1);
        check_eq("single_count", log_addr.size(), base + 1);
        check_eq("single_empty", bus.wb_empty_o, 1'b1);

        // Full buffer drops a distinct 5th line
        ack_en = 1'b0;
        base   = log_addr.size();
        for (int i = 0; i < 4; i++) push(full_addr[i], {96'h0, full_addr[i]});
        check_eq("full_set", bus.wb_full_o, 1'b1);
        push(32'h0000_0500, 128'h5);
        check_eq("full_still", bus.wb_full_o, 1'b1);
        ack_en = 1'b1;
        wait_empty("full");
        check_eq("full_full_clear", bus.wb_full_o, 1'b0);
        check_eq("full_count", log_addr.size(), base + 4);
        for (int i = 0; i < 4; i++)
            check_log("full_drain", base + i, 1'b1, full_addr[i], {96'h0, full_addr[i]});

        // Fill beats queued drains
        base = log_addr.size();
        push(32'h0000_0600, 128'h600);
        bus.fill_req_i  = 1'b1;
        bus.fill_addr_i = 32'h0000_2000;
        push(32'h0000_0700, 128'h700);
        wait_fill("prio", fdata, cyc);
        check_eq("prio_data", fdata, 128'hDEADBEEF_00000000_00000000_00002000);
        wait_empty("prio");
        check_log("prio_read", base, 1'b0, 32'h0000_2000, '0);
        check_log("prio_w0", base + 1, 1'b1, 32'h0000_0600, 128'h600);
        check_log("prio_w1", base + 2, 1'b1, 32'h0000_0700, 128'h700);

        // Read-after-write hazard on a buffered line
        base = log_addr.size();
        push(32'h0000_3000, DA);
        bus.fill_req_i  = 1'b1;
        bus.fill_addr_i = 32'h0000_3000;
        wait_fill("raw", fdata, cyc);
`ifdef DCACHE_WB_FWD_EN
        check_eq("raw_latency", cyc, 1);
        check_eq("raw_fwd_data", fdata, DA);
        wait_empty("raw");
        check_eq("raw_no_read", log_addr.size(), base + 1);
        check_log("raw_write", base, 1'b1, 32'h0000_3000, DA);
`else
        check_eq("raw_mem_data", fdata, 128'hDEADBEEF_00000000_00000000_00003000);
        wait_empty("raw");
        check_log("raw_write_first", base, 1'b1, 32'h0000_3000, DA);
        check_log("raw_read_after", base + 1, 1'b0, 32'h0000_3000, '0);
`endif

        // Coalesce while another line drains
        ack_en = 1'b0;
        base   = log_addr.size();
        push(32'h0000_0800, DX);
        step();
        push(32'h0000_0040, DA);
        push(32'h0000_0040, DB);
        check_eq("coal_drain_req", bus.mem_req_o, 1'b1);
        check_eq("coal_drain_addr", bus.mem_addr_o, 32'h0000_0800);
        ack_en = 1'b1;
        wait_empty("coal");
        check_eq("coal_count", log_addr.size(), base + 2);
        check_log("coal_w0", base, 1'b1, 32'h0000_0800, DX);
        check_log("coal_w1", base + 1, 1'b1, 32'h0000_0040, DB);

        // Reset in the middle of a drain, then a stray ack
        ack_en = 1'b0;
        base   = log_addr.size();
        push(32'h0000_0900, D1);
        step();
        check_eq("mid_req", bus.mem_req_o, 1'b1);
        check_eq("mid_wr", bus.mem_wr_o, 1'b1);
        check_eq("mid_addr", bus.mem_addr_o, 32'h0000_0900);
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_req", bus.mem_req_o, 1'b0);
        check_eq("mid_rst_empty", bus.wb_empty_o, 1'b1);
        rst_n      = 1'b1;
        inject_ack = 1'b1;
        step();
        inject_ack = 1'b0;
        repeat (3) step();
        check_eq("late_ack_req", bus.mem_req_o, 1'b0);
        check_eq("late_ack_empty", bus.wb_empty_o, 1'b1);
        check_eq("late_ack_full", bus.wb_full_o, 1'b0);
        check_eq("late_ack_nolog", log_addr.size(), base);
        ack_en = 1'b1;
        push(32'h0000_0A00, DB);
        wait_empty("post_rst");
        check_eq("post_rst_count", log_addr.size(), base + 1);
        check_log("post_rst_w", base, 1'b1, 32'h0000_0A00, DB);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
